// File: rtl/imem_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and instruction memory.
interface imem_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) ();
    logic               req;
    logic [ADDR_W-1:0]  addr;
    logic               ack;
    logic [INSTR_W-1:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// MINI-RISC instruction fetch front end: single-outstanding memory fetch into a small
// prefetch buffer, with sequential advance, jump redirect and halt driven by decode.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic               clk,
    input  logic               rst,
    imem_if.master             imem,
    input  logic               i_stall,
    input  logic               i_inc_pc,
    input  logic               i_jump,
    input  logic [ADDR_W-1:0]  i_jump_target,
    output logic               o_instr_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [4:0]         o_opcode,
    output logic [ADDR_W-1:0]  o_instr_pc,
    output logic               o_halted
);
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_HALTED   = 2'd2
    } state_t;

    localparam int                CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_0   = {CNT_W{1'b0}};
    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
    localparam logic [4:0]        OPC_NOP = 5'b00000;

    state_t             r_state, w_state;
    logic               r_req, w_req;
    logic [ADDR_W-1:0]  r_addr, w_addr;
    logic [ADDR_W-1:0]  r_fetch_pc, w_fetch_pc;
    logic [CNT_W-1:0]   r_count, w_count;
    logic [INSTR_W-1:0] r_buf_instr [DEPTH];
    logic [INSTR_W-1:0] w_buf_instr [DEPTH];
    logic [ADDR_W-1:0]  r_buf_pc    [DEPTH];
    logic [ADDR_W-1:0]  w_buf_pc    [DEPTH];
    logic               r_valid;
    logic [4:0]         r_opcode;
    logic               r_halted;

    logic               w_accept;
    logic               w_flush;
    logic               w_busy;
    logic               w_push;
    logic               w_pop;
    logic [CNT_W-1:0]   w_after_pop;

    // Acks are only meaningful for a live request; data is kept only in RUN.
    assign w_accept    = r_valid & ~i_stall;
    assign w_flush     = w_accept & (i_jump | ~i_inc_pc);
    assign w_busy      = r_req & ~imem.ack;
    assign w_push      = r_req & imem.ack & (r_state == ST_RUN) & ~w_flush;
    assign w_pop       = w_accept & ~w_flush;
    assign w_after_pop = r_count - CNT_W'(w_pop);

    // Prefetch buffer next contents: shift out the head on pop, append at the tail on push.
    always_comb begin
        w_buf_instr = r_buf_instr;
        w_buf_pc    = r_buf_pc;
        for (int i = 0; i < DEPTH - 1; i++) begin
            w_buf_instr[i] = w_pop ? r_buf_instr[i + 1] : r_buf_instr[i];
            w_buf_pc[i]    = w_pop ? r_buf_pc[i + 1]    : r_buf_pc[i];
        end
        for (int i = 0; i < DEPTH; i++) begin
            w_buf_instr[i] = (w_push && (CNT_W'(i) == w_after_pop)) ? imem.rdata : w_buf_instr[i];
            w_buf_pc[i]    = (w_push && (CNT_W'(i) == w_after_pop)) ? r_addr     : w_buf_pc[i];
        end
        w_count = w_flush ? CNT_0 : (w_after_pop + CNT_W'(w_push));
    end

    // Fetch FSM: request issue, redirect and halt sequencing.
    always_comb begin
        w_state    = r_state;
        w_req      = w_busy;
        w_addr     = r_addr;
        w_fetch_pc = r_fetch_pc;
        case (r_state)
            ST_RUN: begin
                if (w_accept && i_jump) begin
                    if (w_busy) begin
                        w_state    = ST_REDIRECT;
                        w_fetch_pc = i_jump_target;
                    end else begin
                        w_req      = 1'b1;
                        w_addr     = i_jump_target;
                        w_fetch_pc = i_jump_target + PC_ONE;
                    end
                end else if (w_accept && !i_inc_pc) begin
                    w_state = ST_HALTED;
                end else if (!w_busy && (w_count < DEPTH_C)) begin
                    w_req      = 1'b1;
                    w_addr     = r_fetch_pc;
                    w_fetch_pc = r_fetch_pc + PC_ONE;
                end else begin
                    w_state = ST_RUN;
                end
            end
            ST_REDIRECT: begin
                // The stale fetch completes this cycle; its data is dropped and the target issues.
                if (!w_busy) begin
                    w_state    = ST_RUN;
                    w_req      = 1'b1;
                    w_addr     = r_fetch_pc;
                    w_fetch_pc = r_fetch_pc + PC_ONE;
                end else begin
                    w_state = ST_REDIRECT;
                end
            end
            ST_HALTED: begin
                w_state = ST_HALTED;
            end
            default: begin
                w_state = ST_RUN;
                w_req   = 1'b0;
            end
        endcase
    end

    // State, bus and buffer registers; decode-facing outputs are registered copies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_fetch_pc <= RESET_PC;
            r_count    <= CNT_0;
            r_valid    <= 1'b0;
            r_opcode   <= OPC_NOP;
            r_halted   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf_instr[i] <= {INSTR_W{1'b0}};
                r_buf_pc[i]    <= {ADDR_W{1'b0}};
            end
        end else begin
            r_state     <= w_state;
            r_req       <= w_req;
            r_addr      <= w_addr;
            r_fetch_pc  <= w_fetch_pc;
            r_count     <= w_count;
            r_buf_instr <= w_buf_instr;
            r_buf_pc    <= w_buf_pc;
            r_valid     <= (w_count != CNT_0);
            r_opcode    <= (w_count != CNT_0) ? w_buf_instr[0][INSTR_W-1 -: 5] : OPC_NOP;
            r_halted    <= (w_state == ST_HALTED);
        end
    end

    assign imem.req      = r_req;
    assign imem.addr     = r_addr;
    assign o_instr_valid = r_valid;
    assign o_instr       = r_buf_instr[0];
    assign o_opcode      = r_opcode;
    assign o_instr_pc    = r_buf_pc[0];
    assign o_halted      = r_halted;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit: memory model with programmable latency,
// decode stimulus from the main sequence, hand-computed expectations.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        inc_pc = 1'b1;
    logic        jump = 1'b0;
    logic [7:0]  jtarget = 8'h00;
    logic        ack_force = 1'b0;
    logic        mdl_ack = 1'b0;
    logic [15:0] mdl_rdata = 16'h0000;
    int          lat = 0;
    int          wcnt = 0;

    logic        o_valid;
    logic [15:0] o_instr;
    logic [4:0]  o_opc;
    logic [7:0]  o_pc;
    logic        o_halted;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0]  acc_q  [$];
    logic [15:0] acci_q [$];
    logic [7:0]  ack_q  [$];

    imem_if #(.ADDR_W(8), .INSTR_W(16)) bus ();
    assign bus.ack   = mdl_ack | ack_force;
    assign bus.rdata = mdl_rdata;

    instr_fetch_unit #(
        .ADDR_W(8), .INSTR_W(16), .DEPTH(2), .RESET_PC(8'h00)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem          (bus),
        .i_stall       (stall),
        .i_inc_pc      (inc_pc),
        .i_jump        (jump),
        .i_jump_target (jtarget),
        .o_instr_valid (o_valid),
        .o_instr       (o_instr),
        .o_opcode      (o_opc),
        .o_instr_pc    (o_pc),
        .o_halted      (o_halted)
    );

    always #5 clk = ~clk;

    // Instruction memory: imem[i] = 16'h1000 + i, ack after 'lat' waiting cycles.
    always @(negedge clk) begin
        if (rst || !bus.req) begin
            mdl_ack <= 1'b0;
            wcnt    <= 0;
        end else if (wcnt >= lat) begin
            mdl_ack   <= 1'b1;
            mdl_rdata <= 16'h1000 + {8'h00, bus.addr};
            wcnt      <= 0;
        end else begin
            mdl_ack <= 1'b0;
            wcnt    <= wcnt + 1;
        end
    end

    // Record accepted instructions and completed fetch addresses.
    always @(posedge clk) begin
        if (!rst) begin
            if (o_valid && !stall) begin
                acc_q.push_back(o_pc);
                acci_q.push_back(o_instr);
            end
            if (bus.req && bus.ack) ack_q.push_back(bus.addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0; inc_pc = 1'b1; jump = 1'b0; jtarget = 8'h00; ack_force = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        acc_q.delete(); acci_q.delete(); ack_q.delete();
    endtask

    task automatic wait_head(input logic [7:0] pc, input int bound, input string tag);
        int n = 0;
        while (!(o_valid && o_pc == pc) && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, (o_valid && o_pc == pc)}, 32'd1);
    endtask

    task automatic wait_acc(input int cnt, input int bound, input string tag);
        int n = 0;
        while (acc_q.size() < cnt && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, acc_q.size() >= cnt}, 32'd1);
    endtask

    initial begin
        int reqs;
        int bad;
        int n;

        // 1: reset state, zero-wait streaming
        lat = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req", bus.req, 1'b0);
        chk("rst_addr", bus.addr, 8'h00);
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_instr", o_instr, 16'h0000);
        chk("rst_opcode", o_opc, 5'd0);
        chk("rst_pc", o_pc, 8'h00);
        chk("rst_halted", o_halted, 1'b0);
        do_reset();
        @(negedge clk);
        chk("t1_req0", bus.req, 1'b1);
        chk("t1_addr0", bus.addr, 8'h00);
        chk("t1_valid0", o_valid, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t1_valid", o_valid, 1'b1);
            chk("t1_pc", o_pc, k[7:0]);
            chk("t1_instr", o_instr, 16'h1000 + k[15:0]);
            chk("t1_opcode", o_opc, 5'd2);
            chk("t1_next_addr", bus.addr, k[7:0] + 8'd1);
        end

        // 2: stall fills the buffer, then drains in order
        do_reset();
        stall = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t2_first_valid", o_valid, 1'b1);
        reqs = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.req) reqs++;
        end
        chk("t2_req_low", reqs, 0);
        chk("t2_fetched", ack_q.size(), 2);
        chk("t2_head_pc", o_pc, 8'h00);
        stall = 1'b0;
        wait_acc(4, 30, "t2_drain_timeout");
        for (int k = 0; k < 4; k++) begin
            if (k < acc_q.size()) begin
                chk("t2_order_pc", acc_q[k], k[7:0]);
                chk("t2_order_instr", acci_q[k], 16'h1000 + k[15:0]);
            end
        end

        // 3: jump while fetch of addr 3 is outstanding
        lat = 3;
        do_reset();
        wait_head(8'h02, 60, "t3_reach_pc2");
        chk("t3_outstanding_req", bus.req, 1'b1);
        chk("t3_outstanding_addr", bus.addr, 8'h03);
        jump = 1'b1; jtarget = 8'h40;
        @(negedge clk);
        jump = 1'b0;
        chk("t3_flushed", o_valid, 1'b0);
        chk("t3_hold_addr", bus.addr, 8'h03);
        n = 0;
        while (!(bus.req && bus.addr == 8'h40) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t3_redirect_addr", bus.addr, 8'h40);
        wait_head(8'h40, 20, "t3_reach_40");
        chk("t3_instr40", o_instr, 16'h1040);
        repeat (4) @(negedge clk);
        bad = 0;
        foreach (acc_q[i]) if (acc_q[i] == 8'h03) bad++;
        chk("t3_no_addr3", bad, 0);

        // 4: halt
        lat = 0;
        do_reset();
        wait_head(8'h01, 10, "t4_reach_pc1");
        chk("t4_opcode_live", o_opc, 5'd2);
        inc_pc = 1'b0;
        @(negedge clk);
        inc_pc = 1'b1;
        chk("t4_halted", o_halted, 1'b1);
        chk("t4_valid", o_valid, 1'b0);
        chk("t4_opcode_nop", o_opc, 5'd0);
        reqs = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.req) reqs++;
        end
        chk("t4_no_req", reqs, 0);
        chk("t4_still_halted", o_halted, 1'b1);

        // 5: address wrap after jump to 0xFE
        do_reset();
        wait_head(8'h00, 10, "t5_reach_pc0");
        jump = 1'b1; jtarget = 8'hFE;
        @(negedge clk);
        jump = 1'b0;
        acc_q.delete(); acci_q.delete(); ack_q.delete();
        chk("t5_req_fe", bus.addr, 8'hFE);
        wait_acc(3, 20, "t5_timeout");
        if (acc_q.size() >= 3 && ack_q.size() >= 3) begin
            chk("t5_pc_fe", acc_q[0], 8'hFE);
            chk("t5_pc_ff", acc_q[1], 8'hFF);
            chk("t5_pc_00", acc_q[2], 8'h00);
            chk("t5_instr_fe", acci_q[0], 16'h10FE);
            chk("t5_instr_00", acci_q[2], 16'h1000);
            chk("t5_addr_fe", ack_q[0], 8'hFE);
            chk("t5_addr_ff", ack_q[1], 8'hFF);
            chk("t5_addr_00", ack_q[2], 8'h00);
        end

        // 6: reset mid-request, stray ack after release
        lat = 3;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        chk("t6_req_pending", bus.req, 1'b1);
        rst = 1'b1;
        #1;
        chk("t6_req_drop", bus.req, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        ack_force = 1'b1;
        @(negedge clk);
        ack_force = 1'b0;
        chk("t6_stray_ignored", o_valid, 1'b0);
        chk("t6_restart_req", bus.req, 1'b1);
        chk("t6_restart_addr", bus.addr, 8'h00);
        wait_head(8'h00, 20, "t6_reach_pc0");
        chk("t6_instr0", o_instr, 16'h1000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
